// File: rtl/pc_request_unit.sv
// PC register and fetch/data request sequencer.
// Holds the PC across memory waits and retires one instruction per update.
module pc_request_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        dren_in,
  input  logic        dwen_in,
  input  logic [1:0]  PCSrc,
  input  logic [25:0] j_addr26,
  input  logic [31:0] jr_addr,
  input  logic [31:0] imm_ext,
  input  logic        ihit,
  input  logic        dhit,
  output logic        iREN,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] imemaddr,
  output logic [31:0] pc_plus4,
  output logic        pc_commit
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] npc;
  logic        commit;

  assign imemaddr  = pc;
  assign pc_plus4  = pc + 32'd4;
  assign pc_commit = commit & ~RST;

  // Next-PC select; all arithmetic wraps modulo 2^32.
  always_comb begin
    npc = pc_plus4;
    unique case (PCSrc)
      2'd0: npc = pc_plus4;
      2'd1: npc = {pc_plus4[31:28], j_addr26, 2'b00};
      2'd2: npc = jr_addr;
      2'd3: npc = pc_plus4 + (imm_ext << 2);
      default: npc = pc_plus4;
    endcase
  end

  // Sequencer: request outputs, next state and PC update.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    commit    = 1'b0;
    iREN      = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    unique case (state)
      FETCH: begin
        iREN = 1'b1;
        if (halt) begin
          state_nxt = HALTED;
        end else if (ihit) begin
          if (dren_in | dwen_in) begin
            state_nxt = DATA;
          end else begin
            pc_nxt = npc;
            commit = 1'b1;
          end
        end
      end
      DATA: begin
        dREN = dren_in;
        dWEN = dwen_in;
        if (halt) begin
          state_nxt = HALTED;
        end else if (dhit) begin
          pc_nxt    = npc;
          commit    = 1'b1;
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
      pc    <= PC_INIT;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_request_unit.sv
// Testbench for pc_request_unit: directed steps plus random
// stimulus checked against a behavioural model of the sequencer.
module tb_pc_request_unit;

  localparam logic [31:0] PC_INIT = 32'h00000000;

  localparam int M_FETCH  = 0;
  localparam int M_DATA   = 1;
  localparam int M_HALTED = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        halt;
  logic        dren_in;
  logic        dwen_in;
  logic [1:0]  PCSrc;
  logic [25:0] j_addr26;
  logic [31:0] jr_addr;
  logic [31:0] imm_ext;
  logic        ihit;
  logic        dhit;
  logic        iREN;
  logic        dREN;
  logic        dWEN;
  logic [31:0] imemaddr;
  logic [31:0] pc_plus4;
  logic        pc_commit;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  int          m_mode;

  pc_request_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK),
    .RST(RST),
    .halt(halt),
    .dren_in(dren_in),
    .dwen_in(dwen_in),
    .PCSrc(PCSrc),
    .j_addr26(j_addr26),
    .jr_addr(jr_addr),
    .imm_ext(imm_ext),
    .ihit(ihit),
    .dhit(dhit),
    .iREN(iREN),
    .dREN(dREN),
    .dWEN(dWEN),
    .imemaddr(imemaddr),
    .pc_plus4(pc_plus4),
    .pc_commit(pc_commit)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_npc();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    case (PCSrc)
      2'd0: return p4;
      2'd1: return {p4[31:28], j_addr26, 2'b00};
      2'd2: return jr_addr;
      default: return p4 + imm_ext * 32'd4;
    endcase
  endfunction

  function automatic bit model_retire();
    if (RST || halt) return 1'b0;
    if (m_mode == M_FETCH) return ihit && !(dren_in || dwen_in);
    if (m_mode == M_DATA) return dhit;
    return 1'b0;
  endfunction

  // Check all outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    bit          retire;
    logic [31:0] npc;
    #1;
    retire = model_retire();
    npc    = model_npc();
    check("iREN", {31'd0, iREN}, {31'd0, m_mode == M_FETCH});
    check("dREN", {31'd0, dREN}, {31'd0, m_mode == M_DATA && dren_in});
    check("dWEN", {31'd0, dWEN}, {31'd0, m_mode == M_DATA && dwen_in});
    check("imemaddr", imemaddr, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("pc_commit", {31'd0, pc_commit}, {31'd0, retire});
    @(posedge CLK);
    if (RST) begin
      m_pc   = PC_INIT;
      m_mode = M_FETCH;
    end else if (halt) begin
      m_mode = M_HALTED;
    end else if (m_mode == M_FETCH && ihit) begin
      if (dren_in || dwen_in) m_mode = M_DATA;
      else m_pc = npc;
    end else if (m_mode == M_DATA && dhit) begin
      m_pc   = npc;
      m_mode = M_FETCH;
    end
    #1;
  endtask

  task automatic idle_inputs();
    RST = 0; halt = 0; dren_in = 0; dwen_in = 0;
    PCSrc = 0; j_addr26 = 0; jr_addr = 0; imm_ext = 0;
    ihit = 0; dhit = 0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    idle_inputs();
    ihit = 1; PCSrc = 2'd2; jr_addr = v;
    cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    m_pc   = PC_INIT;
    m_mode = M_FETCH;
    cycle();
    check("reset_pc", imemaddr, PC_INIT);
    check("reset_iren", {31'd0, iREN}, 32'd1);

    idle_inputs();
    ihit = 1;
    repeat (3) cycle();
    check("add4_seq", imemaddr, 32'h0000000C);

    set_pc(32'h10);
    dren_in = 1; ihit = 1;
    cycle();
    check("data_hold_pc", imemaddr, 32'h10);
    check("data_dren", {31'd0, dREN}, 32'd1);
    ihit = 0;
    repeat (3) cycle();
    dhit = 1;
    cycle();
    check("data_done_pc", imemaddr, 32'h14);
    idle_inputs();
    cycle();

    set_pc(32'h40000010);
    ihit = 1; PCSrc = 2'd1; j_addr26 = 26'h0000100;
    cycle();
    check("jump", imemaddr, 32'h40000400);

    set_pc(32'h20);
    ihit = 1; PCSrc = 2'd3; imm_ext = 32'hFFFFFFFE;
    cycle();
    check("branch_back", imemaddr, 32'h1C);

    idle_inputs();
    ihit = 1; PCSrc = 2'd2; jr_addr = 32'h1234;
    cycle();
    check("jr", imemaddr, 32'h1234);

    set_pc(32'hFFFFFFFC);
    ihit = 1;
    cycle();
    check("wrap", imemaddr, 32'h0);

    set_pc(32'h80);
    dwen_in = 1; ihit = 1;
    cycle();
    halt = 1; dhit = 1;
    cycle();
    halt = 0; dhit = 1; ihit = 1;
    repeat (2) cycle();
    check("halted_pc", imemaddr, 32'h80);
    check("halted_iren", {31'd0, iREN}, 32'd0);
    check("halted_dwen", {31'd0, dWEN}, 32'd0);
    idle_inputs();
    RST = 1;
    cycle();
    check("halt_reset_pc", imemaddr, PC_INIT);

    set_pc(32'h300);
    RST = 1; ihit = 1; halt = 1;
    cycle();
    check("rst_prio_pc", imemaddr, PC_INIT);
    check("rst_prio_iren", {31'd0, iREN}, 32'd1);

    set_pc(32'h500);
    dren_in = 1; ihit = 1;
    cycle();
    RST = 1; dhit = 1;
    cycle();
    check("rst_mid_data_dren", {31'd0, dREN}, 32'd0);
    check("rst_mid_data_pc", imemaddr, PC_INIT);

    for (int i = 0; i < 400; i++) begin
      RST      = ($urandom_range(0, 29) == 0);
      halt     = ($urandom_range(0, 39) == 0);
      dren_in  = ($urandom_range(0, 3) == 0);
      dwen_in  = ($urandom_range(0, 3) == 0);
      PCSrc    = 2'($urandom_range(0, 3));
      j_addr26 = 26'($urandom);
      jr_addr  = $urandom;
      imm_ext  = $urandom;
      ihit     = $urandom_range(0, 1) == 1;
      dhit     = $urandom_range(0, 1) == 1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
